sram_1rw_ctrl: RTL and testbench
================================

// Module: sram_1rw_ctrl
// PURPOSE
//  Initiator-side controller for the single-port 1RW SRAM macros (CSb/WEb/OEb, shared inout DATA).
//  Converts a valid/ready request stream into correctly sequenced SRAM cycles.
//  Owns the tristate turnaround on DATA and returns read data on a one-cycle response pulse.
//  Sits between the core datapath and one sram_1rw_* instance; both share one clock.
// PARAMETERS
//  DATA_WIDTH  32  SRAM word width; must match the attached macro
//  ADDR_WIDTH  8   SRAM address width; depth = 1<<ADDR_WIDTH
// PORTS
//  clk         in     1           clock, shared with the SRAM macro
//  rstb        in     1           asynchronous reset, active low
//  req_valid   in     1           request present
//  req_ready   out    1           controller can accept a request
//  req_we      in     1           1 = write, 0 = read
//  req_addr    in     ADDR_WIDTH  word address
//  req_wdata   in     DATA_WIDTH  write data, ignored for reads
//  rsp_valid   out    1           one-cycle pulse: request completed
//  rsp_we      out    1           type of the completed request
//  rsp_rdata   out    DATA_WIDTH  read data; valid when rsp_valid && !rsp_we
//  sram_addr   out    ADDR_WIDTH  to SRAM ADDR
//  sram_csb    out    1           to SRAM CSb, active low
//  sram_web    out    1           to SRAM WEb, active low
//  sram_oeb    out    1           to SRAM OEb, active low
//  sram_data   inout  DATA_WIDTH  to SRAM DATA; driven only in WRITE, else 'z
// BEHAVIOUR
//  - Every output is a flop, except req_ready (decoded from state) and the sram_data enable.
//  - Reset (rstb=0, async, any state):
//    - state=IDLE; sram_csb=1, sram_web=1, sram_oeb=1; sram_addr=0; sram_data='z.
//    - rsp_valid=0, rsp_we=0, rsp_rdata=0.
//    - A cycle in flight is abandoned with no response.
//  - FSM states: IDLE, WRITE, READ, CAPTURE. req_ready = (state==IDLE).
//  - IDLE: csb=1, web=1, oeb=1.
//    - On an edge with req_valid && req_ready: latch addr/we/wdata into sram_addr and the wdata register.
//    - we=1 -> WRITE. we=0 -> READ.
//  - WRITE, one cycle:
//    - csb=0, web=0, oeb=1; sram_data driven with latched wdata.
//    - The SRAM writes on the closing edge.
//    - -> IDLE; rsp_valid=1, rsp_we=1 on the following cycle.
//  - READ, one cycle:
//    - csb=0, web=1, oeb=0; sram_data='z.
//    - The SRAM launches data_out on the closing edge.
//    - -> CAPTURE.
//  - CAPTURE, one cycle:
//    - csb=0, web=1, oeb=0; addr held, so the SRAM repeats a harmless read of the same word.
//    - The closing edge registers sram_data into rsp_rdata.
//    - -> IDLE; rsp_valid=1, rsp_we=0 on the following cycle.
//  - Latency, accept edge to rsp_valid high: write 2 cycles, read 3 cycles.
//  - Throughput: one request per 2 cycles (write) or 3 cycles (read).
//  - rsp_valid is a single-cycle pulse with no backpressure. It may coincide with req_ready=1.
//  - Bus turnaround: the controller drives sram_data only when sram_oeb=1 and sram_web=0.
//    - Never drive sram_data in the same cycle as csb=0 && oeb=0 && web=1.
//    - WRITE is entered only from IDLE, so a read never directly precedes a write.
//  - The clock period must exceed the SRAM read DELAY. The CAPTURE edge samples settled data.
//  - sram_addr and control only change on clk edges; no glitches mid-cycle.
//  - rsp_rdata holds its last read value across writes and idle cycles.
//  - Address wraps naturally at the ADDR_WIDTH boundary; no range checking.
// TESTING (bench: sram_1rw_32b_256w model, DELAY=3, clk period 10)
//  - Write 0xDEADBEEF @0x12, then read @0x12 -> write rsp 2 cycles after accept;
//    read rsp 3 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_we=0.
//  - req_valid held high with 4 mixed W/R requests -> req_ready low in WRITE/READ/CAPTURE;
//    each accepted exactly once, in order; no dropped or duplicated responses.
//  - Write 0xFFFFFFFF @0xFF and 0x00000001 @0x00, then read both -> exact values, no aliasing.
//  - Bus monitor over all tests -> sram_data never X while oeb=0 && csb=0 at the CAPTURE edge;
//    no cycle where both the controller and the SRAM drive.
//  - Assert rstb=0 mid-CAPTURE -> outputs take reset values immediately; no rsp_valid;
//    after release, the next read returns correct data.
//  - Idle 20 cycles after reset -> csb=web=oeb=1, sram_data='z, rsp_valid=0 throughout.

Source files
------------

// File: rtl/sram_1rw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_1rw_ctrl
// Description : Initiator-side controller for a single-port 1RW SRAM macro.
//               Turns a valid/ready request stream into sequenced
//               CSb/WEb/OEb cycles, owns the DATA tristate turnaround and
//               returns completions on a one-cycle response pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_1rw_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_we,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic                  sram_oeb,
    inout  wire  [DATA_WIDTH-1:0] sram_data
);

    // Controller states; the request type is implied by WRITE vs READ.
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_WRITE   = 2'd1;
    localparam logic [1:0] c_READ    = 2'd2;
    localparam logic [1:0] c_CAPTURE = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  w_accept;
    logic                  w_drive;

    logic                  w_csb_nxt;
    logic                  w_web_nxt;
    logic                  w_oeb_nxt;
    logic                  w_rsp_valid_nxt;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_csb;
    logic                  r_web;
    logic                  r_oeb;
    logic                  r_rsp_valid;
    logic                  r_rsp_we;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    assign req_ready = (r_state == c_IDLE);
    assign w_accept  = req_valid && req_ready;

    // Only the WRITE state drives the bus. In that state oeb=1 and web=0,
    // so the macro's output driver is guaranteed off.
    assign w_drive   = (r_state == c_WRITE);
    assign sram_data = w_drive ? r_wdata : {DATA_WIDTH{1'bz}};

    assign sram_addr = r_addr;
    assign sram_csb  = r_csb;
    assign sram_web  = r_web;
    assign sram_oeb  = r_oeb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_we    = r_rsp_we;
    assign rsp_rdata = r_rsp_rdata;

    // State register; reset abandons any cycle in flight.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: every access returns to IDLE, so WRITE is never
    // entered straight out of a read.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = req_we ? c_WRITE : c_READ;
                end
            end
            c_WRITE:   w_state_nxt = c_IDLE;
            c_READ:    w_state_nxt = c_CAPTURE;
            c_CAPTURE: w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    // Output decode from the next state so the registered strobes line up
    // with the state they belong to, without any combinational glitching.
    always_comb begin
        w_csb_nxt       = 1'b1;
        w_web_nxt       = 1'b1;
        w_oeb_nxt       = 1'b1;
        w_rsp_valid_nxt = (r_state == c_WRITE) || (r_state == c_CAPTURE);
        case (w_state_nxt)
            c_WRITE: begin
                w_csb_nxt = 1'b0;
                w_web_nxt = 1'b0;
            end
            c_READ, c_CAPTURE: begin
                // CAPTURE keeps the read asserted on the same address; the
                // repeated read is harmless and keeps DATA stable.
                w_csb_nxt = 1'b0;
                w_oeb_nxt = 1'b0;
            end
            default: begin
                w_csb_nxt = 1'b1;
            end
        endcase
    end

    // Registered SRAM strobes, request latches and response outputs.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_csb       <= 1'b1;
            r_web       <= 1'b1;
            r_oeb       <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_csb       <= w_csb_nxt;
            r_web       <= w_web_nxt;
            r_oeb       <= w_oeb_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_rsp_valid_nxt) begin
                r_rsp_we <= (r_state == c_WRITE);
            end
            // The macro launched its data at the closing edge of READ; it has
            // settled by the closing edge of CAPTURE.
            if (r_state == c_CAPTURE) begin
                r_rsp_rdata <= sram_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sram_1rw_ctrl
// Description : Bench for sram_1rw_ctrl with a behavioural 32x256 SRAM
//               (DELAY=3, clk period 10) and a transaction-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_1rw_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] sram_addr;
    logic          sram_csb;
    logic          sram_web;
    logic          sram_oeb;
    wire  [DW-1:0] sram_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_1rw_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .sram_addr(sram_addr), .sram_csb(sram_csb), .sram_web(sram_web),
        .sram_oeb(sram_oeb), .sram_data(sram_data)
    );

    // ---------------- behavioural SRAM macro ----------------
    logic [DW-1:0] sram_mem [0:255];
    logic [DW-1:0] m_dout = '0;
    wire           m_drive = !sram_csb && !sram_oeb && sram_web;
    assign sram_data = m_drive ? m_dout : {DW{1'bz}};

    always @(posedge clk) if (!sram_csb && !sram_web) sram_mem[sram_addr] <= sram_data;
    always @(posedge clk) if (!sram_csb && sram_web) m_dout <= #3 sram_mem[sram_addr];

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A released bus reads as all-z on a 4-state simulator, as 0 on a 2-state one.
    function automatic logic bus_released(input logic [DW-1:0] v);
        return (v === {DW{1'bz}}) || (v === {DW{1'b0}});
    endfunction

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic          we;
        logic [DW-1:0] rdata;
        int            due;
    } exp_t;

    logic [DW-1:0] ref_mem [0:255];
    exp_t          sb_q[$];
    int            cyc = 0;
    int            next_free = 0;
    int            acc_cnt = 0;
    int            rsp_cnt = 0;
    logic [DW-1:0] exp_last = '0;
    logic [DW-1:0] bus_wdata = '0;
    logic          prev_rd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture edge: the word being registered must be fully settled.
    always @(posedge clk) begin
        if (rstb && prev_rd && !sram_csb && !sram_oeb)
            chk("capture_data_known", {63'd0, $isunknown(sram_data)}, 64'd0);
        prev_rd <= rstb && !sram_csb && !sram_oeb && sram_web;
    end

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (!rstb) begin
            sb_q.delete();
            next_free = 0;
            exp_last  = '0;
        end else begin
            // request acceptance: one per write every 2 cycles, read every 3
            chk("req_ready", {63'd0, req_ready}, {63'd0, (cyc >= next_free)});
            // bus ownership
            chk("no_wr_rd_overlap", {61'd0, sram_csb, sram_web, sram_oeb} == 64'd0, 64'd0);
            if (!sram_csb && !sram_web && sram_oeb)
                chk("bus_write_data", {32'd0, sram_data}, {32'd0, bus_wdata});
            else if (m_drive)
                chk("bus_read_only_sram", {32'd0, sram_data}, {32'd0, m_dout});
            else
                chk("bus_released", {63'd0, bus_released(sram_data)}, 64'd1);
            // responses
            if (rsp_valid) begin
                rsp_cnt++;
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_latency", cyc, e.due);
                    chk("rsp_we", {63'd0, rsp_we}, {63'd0, e.we});
                    if (!e.we) begin
                        chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                        exp_last = e.rdata;
                    end
                end
            end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                chk("rsp_present", {63'd0, rsp_valid}, 64'd1);
                void'(sb_q.pop_front());
            end
            chk("rdata_hold", {32'd0, rsp_rdata}, {32'd0, exp_last});
            // accept
            if (req_valid && req_ready) begin
                acc_cnt++;
                lat = req_we ? 2 : 3;
                if (req_we) begin
                    ref_mem[req_addr] = req_wdata;
                    bus_wdata = req_wdata;
                end
                e.we    = req_we;
                e.rdata = ref_mem[req_addr];
                e.due   = cyc + lat;
                sb_q.push_back(e);
                next_free = cyc + lat;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge,
    // with req_valid still high.
    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
            @(posedge clk);
            #1;
            if (done) break;
        end
        if (!done) chk("send_accepted", {63'd0, done}, 64'd1);
    endtask

    // Counts negedges after the accept edge until rsp_valid (0 = timeout).
    task automatic wait_rsp(output int lat, output logic we, output logic [DW-1:0] rd);
        lat = 0;
        we  = 1'b0;
        rd  = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                we  = rsp_we;
                rd  = rsp_rdata;
                break;
            end
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            exp_lat;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int            lat;
        logic          rwe;
        logic [DW-1:0] rd;
        int            acc0;
        int            rsp0;
        int            busy;

        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end

        vecs[0] = '{1'b1, 8'h12, 32'hDEADBEEF, 2, 32'h0};
        vecs[1] = '{1'b0, 8'h12, 32'h0,        3, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 8'hFF, 32'hFFFFFFFF, 2, 32'h0};
        vecs[3] = '{1'b1, 8'h00, 32'h00000001, 2, 32'h0};
        vecs[4] = '{1'b0, 8'hFF, 32'h0,        3, 32'hFFFFFFFF};
        vecs[5] = '{1'b0, 8'h00, 32'h0,        3, 32'h00000001};
        vecs[6] = '{1'b0, 8'h7E, 32'h0,        3, 32'h00000000};
        vecs[7] = '{1'b0, 8'h12, 32'h0,        3, 32'hDEADBEEF};

        // reset state
        rstb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {61'd0, sram_csb, sram_web, sram_oeb}, 64'd7);
        chk("rst_rsp", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_we", {63'd0, rsp_we}, 64'd0);
        chk("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("rst_addr", {56'd0, sram_addr}, 64'd0);
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_bus", {63'd0, bus_released(sram_data)}, 64'd1);
        rstb = 1'b1;

        // idle after reset
        repeat (20) begin
            @(negedge clk);
            chk("idle_ctl", {61'd0, sram_csb, sram_web, sram_oeb}, 64'd7);
            chk("idle_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        @(posedge clk);
        #1;

        // directed table
        foreach (vecs[i]) begin
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            req_valid = 1'b0;
            wait_rsp(lat, rwe, rd);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_we", i), {63'd0, rwe}, {63'd0, vecs[i].we});
            if (!vecs[i].we)
                chk($sformatf("vec%0d_rdata", i), {32'd0, rd}, {32'd0, vecs[i].exp_rdata});
            @(posedge clk);
            #1;
        end

        // req_valid held high across four mixed requests
        acc0 = acc_cnt;
        rsp0 = rsp_cnt;
        busy = 0;
        fork
            begin
                send(1'b1, 8'h30, 32'h11111111);
                send(1'b0, 8'h30, 32'h0);
                send(1'b1, 8'h31, 32'h22222222);
                send(1'b0, 8'h31, 32'h0);
                req_valid = 1'b0;
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (!req_ready) busy++;
                end
            end
        join
        repeat (4) @(negedge clk);
        chk("burst_accepts", acc_cnt - acc0, 4);
        chk("burst_responses", rsp_cnt - rsp0, 4);
        chk("burst_busy_cycles", busy, 6);
        @(posedge clk);
        #1;

        // randomized traffic, kept away from 0x12/0x00/0xFF
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                @(posedge clk);
                #1;
            end else begin
                send(1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 1) != 0 ? $urandom_range(8'h40, 8'h4F)
                                                   : $urandom_range(8'h20, 8'h2F)),
                     $urandom() | 32'h1);
            end
        end
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("drain_empty", sb_q.size(), 0);
        @(posedge clk);
        #1;

        // reset asserted in the middle of CAPTURE
        send(1'b0, 8'h12, 32'h0);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("in_capture", {62'd0, sram_csb, sram_oeb}, 64'd0);
        rstb = 1'b0;
        #1;
        chk("midrst_ctl", {61'd0, sram_csb, sram_web, sram_oeb}, 64'd7);
        chk("midrst_rsp", {63'd0, rsp_valid}, 64'd0);
        chk("midrst_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("midrst_addr", {56'd0, sram_addr}, 64'd0);
        chk("midrst_bus", {63'd0, bus_released(sram_data)}, 64'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        rstb = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("postrst_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        @(posedge clk);
        #1;
        send(1'b0, 8'h12, 32'h0);
        req_valid = 1'b0;
        wait_rsp(lat, rwe, rd);
        chk("postrst_latency", lat, 3);
        chk("postrst_rdata", {32'd0, rd}, 64'hDEADBEEF);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
